// File: rtl/fpalu_sched_pkg.sv
// Shared types and widths for the FP adder request scheduler.
package fpalu_sched_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/fpalu_add_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo N_REQ. Returns one-hot grant, encoded index and a hit flag.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fpalu_add_sched.sv
// Round-robin scheduler sharing one FP adder among N_REQ requesters.
// Optional FPALU_SCHED_STATS_EN adds saturating stat_ops/stat_ovf counters.
module fpalu_add_sched
    import fpalu_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [FP_W*N_REQ-1:0]   req_a,
    input  logic [FP_W*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [FP_W-1:0]         rsp_s,
    output logic                    rsp_overflow,
    output logic [FP_W-1:0]         add_a,
    output logic [FP_W-1:0]         add_b,
    input  logic [FP_W-1:0]         add_s,
    input  logic                    add_ovf,
    output logic                    busy
`ifdef FPALU_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]       stat_ops,
    output logic [STAT_W-1:0]       stat_ovf
`endif
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FP_W-1:0]  op_a_q, op_a_d;
    logic [FP_W-1:0]  op_b_q, op_b_d;
    logic [FP_W-1:0]  res_s_q, res_s_d;
    logic             res_ovf_q, res_ovf_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             rsp_hs;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign rsp_hs = (state_q == RESP) && rsp_ready[gnt_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_s_d   = res_s_q;
        res_ovf_d = res_ovf_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            IDLE: begin
                // No accept is advertised while reset is held.
                req_ready = rst_n ? arb_gnt : '0;
                if (arb_any) begin
                    state_d = EXEC;
                    gnt_d   = arb_idx;
                    op_a_d  = req_a[arb_idx*FP_W +: FP_W];
                    op_b_d  = req_b[arb_idx*FP_W +: FP_W];
                    cnt_d   = CNT_LOAD;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    res_s_d   = add_s;
                    res_ovf_d = add_ovf;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_hs) begin
                    rr_ptr_d = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_s_q   <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            res_s_q   <= res_s_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    // Operand registers only change on acceptance, so the adder inputs
    // stay quiet outside EXEC.
    assign add_a        = op_a_q;
    assign add_b        = op_b_q;
    assign rsp_s        = res_s_q;
    assign rsp_overflow = res_ovf_q;
    assign busy         = (state_q != IDLE);

`ifdef FPALU_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_ops_q, stat_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else if (rsp_hs) begin
            if (stat_ops_q != '1) begin
                stat_ops_q <= stat_ops_q + 1'b1;
            end
            if (res_ovf_q && (stat_ovf_q != '1)) begin
                stat_ovf_q <= stat_ovf_q + 1'b1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_fpalu_add_sched.sv
// Self-checking bench for fpalu_add_sched with a behavioural FP adder stand-in
// and a transaction-level scheduling model.
module tb_fpalu_add_sched;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [32*N-1:0] req_a = '0, req_b = '0;
    logic [31:0]    rsp_s, add_a, add_b, add_s;
    logic           rsp_overflow, add_ovf, busy;
`ifdef FPALU_SCHED_STATS_EN
    logic [15:0]    stat_ops, stat_ovf;
`endif

    always #5 clk = ~clk;

    fpalu_add_sched #(
        .N_REQ   (N),
        .ADD_LAT (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_s        (rsp_s),
        .rsp_overflow (rsp_overflow),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_s        (add_s),
        .add_ovf      (add_ovf),
        .busy         (busy)
`ifdef FPALU_SCHED_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_ovf     (stat_ovf)
`endif
    );

    // Truncating add of positive normal singles; {overflow, sum}.
    function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  d;
        logic [24:0] mx, my, sum;
        logic [8:0]  e;
        if (a[30:23] >= b[30:23]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d   = x[30:23] - y[30:23];
        mx  = {2'b01, x[22:0]};
        my  = {2'b01, y[22:0]};
        my  = (d > 8'd24) ? '0 : (my >> d);
        sum = mx + my;
        e   = {1'b0, x[30:23]};
        if (sum[24]) begin
            sum = sum >> 1;
            e   = e + 9'd1;
        end
        if (e >= 9'd255) return {1'b1, 32'h7f800000};
        return {1'b0, 1'b0, e[7:0], sum[22:0]};
    endfunction

    always_comb {add_ovf, add_s} = fadd(add_a, add_b);

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_ptr, phase, rem, tgt, m_ops, m_ovf, cyc, gnt_cyc, rsp_cyc;
    bit          pend[N];
    logic [31:0] pa[N], pb[N];
    logic [31:0] m_opa, m_opb, last_s;
    logic [32:0] m_res;
    logic        last_ovf, prev_vld;
    int          gq[$];
    logic [31:0] sq[$];

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    task automatic step(input logic [N-1:0] rr);
        logic [N-1:0] exp_rdy, exp_vld;
        int w, oi, idx;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[32*i +: 32]  = pa[i];
            req_b[32*i +: 32]  = pb[i];
        end
        rsp_ready = rr;
        #1;
`ifdef FPALU_SCHED_STATS_EN
        check_eq("stat_ops", stat_ops, 16'(m_ops));
        check_eq("stat_ovf", stat_ovf, 16'(m_ovf));
`endif
        check_eq("add_a", add_a, m_opa);
        check_eq("add_b", add_b, m_opb);
        exp_rdy = '0;
        exp_vld = '0;
        if (phase == 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            check_eq("idle_ready", req_ready, exp_rdy);
            check_eq("idle_rsp_valid", rsp_valid, exp_vld);
            check_eq("idle_busy", busy, 0);
            if (w >= 0) begin
                oi = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) oi = i;
                gq.push_back(oi);
                gnt_cyc = cyc;
                tgt     = w;
                m_opa   = pa[w];
                m_opb   = pb[w];
                m_res   = fadd(pa[w], pb[w]);
                pend[w] = 1'b0;
                phase   = 1;
                rem     = LAT;
            end
        end else if (phase == 1) begin
            check_eq("exec_ready", req_ready, exp_rdy);
            check_eq("exec_rsp_valid", rsp_valid, exp_vld);
            check_eq("exec_busy", busy, 1);
            rem--;
            if (rem == 0) phase = 2;
        end else begin
            exp_vld[tgt] = 1'b1;
            check_eq("resp_ready", req_ready, exp_rdy);
            check_eq("resp_valid", rsp_valid, exp_vld);
            check_eq("resp_s", rsp_s, m_res[31:0]);
            check_eq("resp_ovf", rsp_overflow, m_res[32]);
            check_eq("resp_busy", busy, 1);
            if ((|rsp_valid) && !prev_vld) rsp_cyc = cyc;
            last_s   = rsp_s;
            last_ovf = rsp_overflow;
            if (rr[tgt]) begin
                sq.push_back(rsp_s);
                m_ptr = (tgt + 1) % N;
                phase = 0;
                m_ops++;
                if (m_res[32]) m_ovf++;
            end
        end
        prev_vld = |rsp_valid;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_s", rsp_s, 0);
        check_eq("rst_rsp_ovf", rsp_overflow, 0);
        check_eq("rst_add_a", add_a, 0);
        check_eq("rst_add_b", add_b, 0);
        check_eq("rst_busy", busy, 0);
`ifdef FPALU_SCHED_STATS_EN
        check_eq("rst_stat_ops", stat_ops, 0);
        check_eq("rst_stat_ovf", stat_ovf, 0);
`endif
        m_ptr = 0; phase = 0; m_opa = '0; m_opb = '0;
        m_ops = 0; m_ovf = 0; prev_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((phase != 0 || any_pend()) && n < maxc) begin
            step('1);
            n++;
        end
        check_eq("drain_timeout", (phase != 0 || any_pend()), 0);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = ($urandom_range(7) == 0) ? 8'd254 : 8'($urandom_range(135, 120));
        return {1'b0, e, 23'($urandom)};
    endfunction

    initial begin
        int stall, reposted;
        int          eo[5];
        logic [31:0] es[5];
        eo = '{0, 1, 2, 3, 0};
        es = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000, 32'h40800000};
        cyc = 0;
        for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end
        #2;
        do_reset();

        // Single request on requester 1
        post(1, 32'h3f800000, 32'h3f800000);
        run_idle(20);
        check_eq("t1_sum", last_s, 32'h40000000);
        check_eq("t1_ovf", last_ovf, 0);
        check_eq("t1_latency", rsp_cyc - gnt_cyc, 3);

        // Overflow on requester 0
        post(0, 32'h7f7fffff, 32'h7f7fffff);
        run_idle(20);
        check_eq("t2_ovf", last_ovf, 1);
`ifdef FPALU_SCHED_STATS_EN
        check_eq("t2_stat_ovf", stat_ovf, 1);
`endif

        // All four from reset, requester 0 re-presents right after its response
        do_reset();
        gq.delete();
        sq.delete();
        for (int i = 0; i < N; i++) post(i, 32'h3f800000, 32'h3f800000 + (i == 0 ? 0 : 32'h00800000 + (i - 1) * 32'h00400000));
        post(3, 32'h3f800000, 32'h40800000);
        reposted = 0;
        for (int n = 0; n < 60 && (reposted == 0 || phase != 0 || any_pend()); n++) begin
            step('1);
            if (reposted == 0 && m_ops >= 1) begin
                post(0, 32'h40000000, 32'h40000000);
                reposted = 1;
            end
        end
        check_eq("t3_count", gq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) check_eq("t3_order", gq[k], eo[k]);
            if (k < sq.size()) check_eq("t3_sum", sq[k], es[k]);
        end

        // Backpressure on requester 2, then rr_ptr must sit at 3
        post(2, 32'h3f800000, 32'h40000000);
        stall = 0;
        for (int n = 0; n < 40 && (stall < 10 || phase != 0 || any_pend()); n++) begin
            if (phase == 2 && stall < 10) begin
                step(4'b1011);
                stall++;
            end else begin
                step('1);
            end
        end
        check_eq("t4_sum", last_s, 32'h40400000);
        post(0, 32'h3f800000, 32'h3f800000);
        post(3, 32'h40000000, 32'h40000000);
        step('1);
        check_eq("t4_ptr_grant", gq[$], 3);
        run_idle(30);

        // Reset while an operation is in EXEC
        post(1, 32'h40000000, 32'h3f800000);
        step('1);
        step('1);
        do_reset();
        for (int n = 0; n < 6; n++) step('1);
        post(1, 32'h40000000, 32'h40000000);
        run_idle(20);
        check_eq("t5_sum", last_s, 32'h40800000);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) post(i, rnd_fp(), rnd_fp());
            end
            step(N'($urandom));
        end
        run_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
